pe_mac: RTL

Parametrised successor to the pass/add processing element in the systolic array. Adds a signed multiply-accumulate with a local accumulator, per-lane valid tags, a global stall and read-and-clear drain. Tiles in an R×C grid. Opcodes enter at column 0 from above and ripple rightward along each row, one cycle per PE, exactly as in the existing array.

---
 rtl/pe_mac_pkg.sv | 26 ++
 rtl/pe_mac_if.sv | 16 +
 rtl/pe_mac_acc.sv | 121 ++++++++++++
 rtl/pe_mac.sv | 86 ++++++++
 4 files changed

// File: rtl/pe_mac_pkg.sv
// Shared types for the pe_mac systolic processing element:
// opcodes, the data-bus bundle and the accumulator FSM states.
package pe_mac_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [2:0] {
        OPCD_PASS  = 3'd0,
        OPCD_ADD   = 3'd1,
        OPCD_MAC   = 3'd2,
        OPCD_CLR   = 3'd3,
        OPCD_DRAIN = 3'd4
    } opcd_t;

    typedef struct packed {
        opcd_t              opcd;
        logic               vld;
        logic [DW_DEF-1:0]  data;
    } dbus_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACC   = 1'b1
    } acc_st_t;

endpackage

// File: rtl/pe_mac_if.sv
// One PE-to-PE data bus: opcode, valid tag and signed data lane.
// master drives the bus, slave receives it.
interface pe_mac_if
    import pe_mac_pkg::*;
#(
    parameter int DW = DW_DEF
) ();

    opcd_t          opcd;
    logic           vld;
    logic [DW-1:0]  data;

    modport master (output opcd, vld, data);
    modport slave  (input  opcd, vld, data);

endinterface

// File: rtl/pe_mac_acc.sv
// Accumulator, drain strobe and empty/acc FSM of the PE.
// PE_MAC_SAT_EN selects clamping arithmetic plus a sticky sat flag.
module pe_mac_acc
    import pe_mac_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = 40
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           stall_i,
    input  opcd_t          rop_i,
    input  logic           both_i,
    input  logic [DW-1:0]  a_i,
    input  logic [DW-1:0]  b_i,
    output logic [AW-1:0]  acc_o,
    output logic           acc_vld_o,
    output logic           sat_o
);

    acc_st_t               st_q, st_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         acc_o_q, acc_o_d;
    logic [AW-1:0]         mac_val;
    logic                  vld_q, vld_d;
    logic signed [2*DW-1:0] prod;

`ifdef PE_MAC_SAT_EN
    logic signed [AW:0]    sum;
    logic                  ovf;
    logic                  sat_q, sat_d;

    // One guard bit: overflow when the two top sum bits disagree.
    always_comb begin
        prod    = (2*DW)'($signed(a_i)) * (2*DW)'($signed(b_i));
        sum     = $signed({acc_q[AW-1], acc_q}) + (AW+1)'(prod);
        ovf     = sum[AW] ^ sum[AW-1];
        mac_val = sum[AW-1:0];
        if (ovf) begin
            mac_val = sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                              : {1'b0, {(AW-1){1'b1}}};
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (rop_i == OPCD_CLR) begin
            sat_d = 1'b0;
        end else if (rop_i == OPCD_MAC && both_i && ovf) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_q <= 1'b0;
        end else if (!stall_i) begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    logic signed [AW-1:0]  sum;

    always_comb begin
        prod    = (2*DW)'($signed(a_i)) * (2*DW)'($signed(b_i));
        sum     = $signed(acc_q) + AW'(prod);
        mac_val = sum;
    end

    assign sat_o = 1'b0;
`endif

    always_comb begin
        st_d    = st_q;
        acc_d   = acc_q;
        acc_o_d = acc_o_q;
        vld_d   = 1'b0;
        case (rop_i)
            OPCD_MAC: begin
                if (both_i) begin
                    acc_d = mac_val;
                    st_d  = ST_ACC;
                end
            end
            OPCD_CLR: begin
                acc_d = '0;
                st_d  = ST_EMPTY;
            end
            OPCD_DRAIN: begin
                acc_o_d = (st_q == ST_ACC) ? acc_q : '0;
                vld_d   = 1'b1;
                acc_d   = '0;
                st_d    = ST_EMPTY;
            end
            default: ;
        endcase
    end

    // Stall freezes everything but still kills a pending drain strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q    <= ST_EMPTY;
            acc_q   <= '0;
            acc_o_q <= '0;
            vld_q   <= 1'b0;
        end else if (stall_i) begin
            vld_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            acc_q   <= acc_d;
            acc_o_q <= acc_o_d;
            vld_q   <= vld_d;
        end
    end

    assign acc_o     = acc_o_q;
    assign acc_vld_o = vld_q;

endmodule

// File: rtl/pe_mac.sv
// Systolic PE: opcode ripple, data forwarding and MAC accumulator.
// Saturating accumulation is enabled by defining PE_MAC_SAT_EN.
module pe_mac
    import pe_mac_pkg::*;
#(
    parameter int R  = 0,
    parameter int C  = 0,
    parameter int DW = DW_DEF,
    parameter int AW = 40
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    pe_mac_if.slave        up,
    pe_mac_if.slave        left,
    pe_mac_if.master       down,
    pe_mac_if.master       right,
    output logic [AW-1:0]  acc_o,
    output logic           acc_vld,
    output logic           sat
);

    if (AW < 2*DW || R < 0 || C < 0) begin : g_bad_param
        $error("pe_mac: AW must hold a full product, R/C >= 0");
    end

    opcd_t          src, rop_q;
    logic           both;
    logic           dn_vld_q, rt_vld_q;
    logic [DW-1:0]  add_sum;
    logic [DW-1:0]  dn_data_d, rt_data_d;
    logic [DW-1:0]  dn_data_q, rt_data_q;

    // rop_q leads the data it governs by one stage.
    always_comb begin
        src       = (C == 0) ? up.opcd : left.opcd;
        both      = up.vld & left.vld;
        add_sum   = up.data + left.data;
        dn_data_d = up.data;
        rt_data_d = left.data;
        if (rop_q == OPCD_ADD) begin
            dn_data_d = add_sum;
            rt_data_d = add_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rop_q     <= OPCD_PASS;
            dn_vld_q  <= 1'b0;
            rt_vld_q  <= 1'b0;
            dn_data_q <= '0;
            rt_data_q <= '0;
        end else if (!stall) begin
            rop_q     <= src;
            dn_vld_q  <= up.vld;
            rt_vld_q  <= left.vld;
            dn_data_q <= dn_data_d;
            rt_data_q <= rt_data_d;
        end
    end

    assign down.opcd  = rop_q;
    assign down.vld   = dn_vld_q;
    assign down.data  = dn_data_q;
    assign right.opcd = rop_q;
    assign right.vld  = rt_vld_q;
    assign right.data = rt_data_q;

    pe_mac_acc #(
        .DW (DW),
        .AW (AW)
    ) u_acc (
        .clk_i     (clk),
        .rst_i     (rst),
        .stall_i   (stall),
        .rop_i     (rop_q),
        .both_i    (both),
        .a_i       (up.data),
        .b_i       (left.data),
        .acc_o     (acc_o),
        .acc_vld_o (acc_vld),
        .sat_o     (sat)
    );

endmodule
